// File: rtl/spn_feeder.sv
// Double-banked frame buffer that feeds a permutation network with gap-free frames
// of MEM_DEPTH vectors, plus on-demand all-zero flush frames.
module spn_feeder #(
    parameter int PARA       = 16,
    parameter int MEM_DEPTH  = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data [PARA-1:0],
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush_req,
    output logic [DATA_WIDTH-1:0] output_stream [PARA-1:0],
    output logic                  valid_out,
    output logic                  busy
);

    localparam int VEC_W  = PARA * DATA_WIDTH;
    localparam int PTR_W  = $clog2(MEM_DEPTH);
    localparam int ADDR_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Bank B0 occupies rows 0..MEM_DEPTH-1, bank B1 the upper half.
    logic [VEC_W-1:0] mem [2*MEM_DEPTH];

    logic [VEC_W-1:0] wr_vec;
    logic [VEC_W-1:0] out_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic             wr_bank_reg;
    logic             rd_bank_reg;
    logic             full_reg [2];
    logic             flush_pending_reg;
    logic             valid_reg;
    state_t           state_reg;

    logic wr_fire;
    logic wr_last;
    logic rd_last;
    logic send_last;
    logic decide;
    logic next_bank;
    logic start_send;
    logic start_flush;

    generate
        for (genvar gi = 0; gi < PARA; gi++) begin : g_lane
            assign wr_vec[gi*DATA_WIDTH +: DATA_WIDTH] = in_data[gi];
            assign output_stream[gi] = out_reg[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign in_ready  = !full_reg[wr_bank_reg];
    assign wr_fire   = in_valid && in_ready;
    assign wr_last   = wr_fire && (wr_ptr_reg == LAST_ROW);
    assign rd_last   = ((state_reg == SEND) || (state_reg == FLUSH)) && (rd_ptr_reg == LAST_ROW);
    assign send_last = (state_reg == SEND) && (rd_ptr_reg == LAST_ROW);

    // On the last row of a data frame the bank under decision is the other one.
    assign decide      = (state_reg == IDLE) || rd_last;
    assign next_bank   = send_last ? ~rd_bank_reg : rd_bank_reg;
    assign start_send  = full_reg[next_bank];
    assign start_flush = !start_send && flush_pending_reg;

    assign valid_out = valid_reg;
    // Stays high through the cycle that presents the final row of a frame.
    assign busy      = (state_reg != IDLE) || valid_reg;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{wr_bank_reg, wr_ptr_reg}] <= wr_vec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg  <= '0;
            wr_bank_reg <= 1'b0;
        end else if (wr_fire) begin
            if (wr_ptr_reg == LAST_ROW) begin
                wr_ptr_reg  <= '0;
                wr_bank_reg <= ~wr_bank_reg;
            end else begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
        end
    end

    // A bank is only set while it is the write bank and only cleared while it is
    // the read bank, and a full bank is never written, so the two never collide.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_full
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    full_reg[gi] <= 1'b0;
                end else if (wr_last && (wr_bank_reg == 1'(gi))) begin
                    full_reg[gi] <= 1'b1;
                end else if (send_last && (rd_bank_reg == 1'(gi))) begin
                    full_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= IDLE;
            rd_ptr_reg        <= '0;
            rd_bank_reg       <= 1'b0;
            flush_pending_reg <= 1'b0;
            out_reg           <= '0;
            valid_reg         <= 1'b0;
        end else begin
            out_reg   <= '0;
            valid_reg <= 1'b0;

            case (state_reg)
                SEND: begin
                    out_reg    <= mem[{rd_bank_reg, rd_ptr_reg}];
                    valid_reg  <= 1'b1;
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                end
                FLUSH: begin
                    valid_reg  <= 1'b1;
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                end
                IDLE: begin
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            if (send_last) begin
                rd_bank_reg <= ~rd_bank_reg;
            end

            if (decide) begin
                if (start_send) begin
                    state_reg  <= SEND;
                    rd_ptr_reg <= '0;
                end else if (start_flush) begin
                    state_reg  <= FLUSH;
                    rd_ptr_reg <= '0;
                end else begin
                    state_reg <= IDLE;
                end
            end

            // A request seen at the edge that launches the flush merges into it.
            if (decide && start_flush) begin
                flush_pending_reg <= 1'b0;
            end else if (flush_req) begin
                flush_pending_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spn_feeder.sv
// Directed bench for spn_feeder: frame latency, bank ping-pong, flush frames,
// reset during a send and irregular write traffic.
module tb_spn_feeder;

    localparam int PARA      = 16;
    localparam int MEM_DEPTH = 16;
    localparam int DW        = 32;
    localparam int VW        = PARA * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data [PARA-1:0];
    logic          in_valid;
    logic          in_ready;
    logic          flush_req;
    logic [DW-1:0] output_stream [PARA-1:0];
    logic          valid_out;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_accept;
    int stall_cnt;
    int first_stall;
    int zero_viol = 0;

    logic [VW-1:0] cap_data [$];
    int            cap_cyc  [$];
    bit            cap_busy [$];
    logic [VW-1:0] mon_vec;

    spn_feeder #(
        .PARA       (PARA),
        .MEM_DEPTH  (MEM_DEPTH),
        .DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .flush_req     (flush_req),
        .output_stream (output_stream),
        .valid_out     (valid_out),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every valid output vector with the edge number that produced it.
    always @(negedge clk) begin
        for (int j = 0; j < PARA; j++) mon_vec[j*DW +: DW] = output_stream[j];
        if (valid_out === 1'b1) begin
            cap_data.push_back(mon_vec);
            cap_cyc.push_back(cyc);
            cap_busy.push_back(busy);
        end else if (mon_vec != '0) begin
            zero_viol++;
        end
    end

    function automatic logic [VW-1:0] row_val(input int r);
        logic [VW-1:0] v;
        for (int j = 0; j < PARA; j++) v[j*DW +: DW] = 32'(r * PARA + j);
        return v;
    endfunction

    function automatic logic [VW-1:0] out_vec();
        logic [VW-1:0] v;
        for (int j = 0; j < PARA; j++) v[j*DW +: DW] = output_stream[j];
        return v;
    endfunction

    task automatic set_row(input int r);
        for (int j = 0; j < PARA; j++) in_data[j] = 32'(r * PARA + j);
    endtask

    task automatic clear_capture();
        cap_data.delete();
        cap_cyc.delete();
        cap_busy.delete();
    endtask

    task automatic write_rows(input int first, input int n, input bit gaps, input bit flush_last);
        int i = 0;
        int guard = 0;
        stall_cnt   = 0;
        first_stall = -1;
        while (i < n && guard < 2000) begin
            @(negedge clk);
            guard++;
            flush_req = 1'b0;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                continue;
            end
            set_row(first + i);
            in_valid = 1'b1;
            if (flush_last && i == n - 1) flush_req = 1'b1;
            if (in_ready === 1'b1) begin
                last_accept = cyc + 1;
                i++;
            end else begin
                stall_cnt++;
                if (first_stall < 0) first_stall = i;
            end
        end
        checks++;
        if (i !== n) begin
            errors++;
            $display("FAIL write_budget: accepted %0d rows, required %0d", i, n);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        flush_req = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        flush_req = 1'b0;
        set_row(0);
        repeat (3) @(negedge clk);
        #1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", valid_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", in_ready); end
        checks++; if (out_vec() !== '0) begin errors++; $display("FAIL reset_data: got %h required 0", out_vec()); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (valid_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: valid %b busy %b required 0 0", valid_out, busy); end
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        int n;
        clear_capture();
        write_rows(0, 16, 1'b0, 1'b0);
        repeat (30) @(negedge clk);
        #1;
        n = (cap_data.size() < 16) ? cap_data.size() : 16;
        checks++; if (cap_data.size() !== 16) begin errors++; $display("FAIL single_count: got %0d required 16", cap_data.size()); end
        if (n > 0) begin
            checks++;
            if (cap_cyc[0] !== last_accept + 2) begin errors++; $display("FAIL single_latency: row0 at edge %0d required %0d", cap_cyc[0], last_accept + 2); end
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (cap_data[i] !== row_val(i) || cap_cyc[i] !== cap_cyc[0] + i || cap_busy[i] !== 1'b1) begin
                errors++;
                $display("FAIL single_row %0d: got %h edge %0d busy %b required %h edge %0d busy 1",
                         i, cap_data[i], cap_cyc[i], cap_busy[i], row_val(i), cap_cyc[0] + i);
            end
        end
        checks++; if (valid_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_end: valid %b busy %b required 0 0", valid_out, busy); end
        $display("test_single_frame done: %0d rows captured", cap_data.size());
    endtask

    task automatic test_back_to_back();
        int n;
        clear_capture();
        write_rows(100, 48, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        #1;
        checks++; if (first_stall !== 32) begin errors++; $display("FAIL b2b_first_stall: after %0d writes required 32", first_stall); end
        checks++; if (stall_cnt !== 1) begin errors++; $display("FAIL b2b_stall_len: got %0d cycles required 1", stall_cnt); end
        n = (cap_data.size() < 48) ? cap_data.size() : 48;
        checks++; if (cap_data.size() !== 48) begin errors++; $display("FAIL b2b_count: got %0d required 48", cap_data.size()); end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (cap_data[i] !== row_val(100 + i)) begin errors++; $display("FAIL b2b_row %0d: got %h required %h", i, cap_data[i], row_val(100 + i)); end
        end
        if (n == 48) begin
            for (int f = 0; f < 3; f++) begin
                checks++;
                if (cap_cyc[16*f + 15] - cap_cyc[16*f] !== 15) begin errors++; $display("FAIL b2b_frame_gap %0d: span %0d required 15", f, cap_cyc[16*f + 15] - cap_cyc[16*f]); end
            end
            checks++;
            if (cap_cyc[16] !== cap_cyc[15] + 1) begin errors++; $display("FAIL b2b_seam: frame1 at %0d required %0d", cap_cyc[16], cap_cyc[15] + 1); end
        end
        $display("test_back_to_back done: %0d rows captured, stall %0d", cap_data.size(), stall_cnt);
    endtask

    task automatic test_flush_idle();
        int pulse_edge;
        int n;
        clear_capture();
        @(negedge clk);
        flush_req  = 1'b1;
        pulse_edge = cyc + 1;
        @(negedge clk);
        flush_req = 1'b1;   // second request overlaps the pending one
        @(negedge clk);
        flush_req = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        n = (cap_data.size() < 16) ? cap_data.size() : 16;
        checks++; if (cap_data.size() !== 16) begin errors++; $display("FAIL flush_count: got %0d required 16", cap_data.size()); end
        if (n > 0) begin
            checks++;
            if (cap_cyc[0] !== pulse_edge + 2) begin errors++; $display("FAIL flush_latency: at edge %0d required %0d", cap_cyc[0], pulse_edge + 2); end
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (cap_data[i] !== '0 || cap_cyc[i] !== cap_cyc[0] + i) begin errors++; $display("FAIL flush_row %0d: got %h edge %0d required 0 edge %0d", i, cap_data[i], cap_cyc[i], cap_cyc[0] + i); end
        end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL flush_end: valid %b required 0", valid_out); end
        $display("test_flush_idle done: %0d rows captured", cap_data.size());
    endtask

    task automatic test_flush_with_frame();
        int n;
        clear_capture();
        write_rows(600, 16, 1'b0, 1'b1);
        repeat (50) @(negedge clk);
        #1;
        n = (cap_data.size() < 32) ? cap_data.size() : 32;
        checks++; if (cap_data.size() !== 32) begin errors++; $display("FAIL fwf_count: got %0d required 32", cap_data.size()); end
        if (n == 32) begin
            checks++;
            if (cap_cyc[0] !== last_accept + 2 || cap_cyc[31] !== cap_cyc[0] + 31) begin
                errors++; $display("FAIL fwf_timing: first %0d last %0d required %0d %0d", cap_cyc[0], cap_cyc[31], last_accept + 2, last_accept + 33);
            end
        end
        for (int i = 0; i < n; i++) begin
            logic [VW-1:0] exp_v;
            exp_v = (i < 16) ? row_val(600 + i) : '0;
            checks++;
            if (cap_data[i] !== exp_v) begin errors++; $display("FAIL fwf_row %0d: got %h required %h", i, cap_data[i], exp_v); end
        end
        $display("test_flush_with_frame done: %0d rows captured", cap_data.size());
    endtask

    task automatic test_reset_mid_send();
        int guard = 0;
        int n;
        clear_capture();
        write_rows(200, 16, 1'b0, 1'b0);
        write_rows(300, 5, 1'b0, 1'b1);   // partial frame and a pending flush
        while (cap_data.size() < 8 && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        checks++;
        if (cap_data.size() !== 8) begin errors++; $display("FAIL rms_reach_row7: captured %0d rows required 8", cap_data.size()); end
        else begin
            checks++;
            if (cap_data[7] !== row_val(207)) begin errors++; $display("FAIL rms_row7: got %h required %h", cap_data[7], row_val(207)); end
        end
        rst = 1'b0;
        #1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rms_valid: got %b required 0", valid_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rms_ready: got %b required 1", in_ready); end
        checks++; if (busy !== 1'b0 || out_vec() !== '0) begin errors++; $display("FAIL rms_state: busy %b data %h required 0 0", busy, out_vec()); end
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        checks++; if (cap_data.size() !== 8) begin errors++; $display("FAIL rms_quiet: captured %0d rows required 8", cap_data.size()); end
        clear_capture();
        write_rows(400, 16, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        #1;
        n = (cap_data.size() < 16) ? cap_data.size() : 16;
        checks++; if (cap_data.size() !== 16) begin errors++; $display("FAIL rms_new_count: got %0d required 16", cap_data.size()); end
        if (n > 0) begin
            checks++;
            if (cap_cyc[0] !== last_accept + 2) begin errors++; $display("FAIL rms_new_latency: at edge %0d required %0d", cap_cyc[0], last_accept + 2); end
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (cap_data[i] !== row_val(400 + i)) begin errors++; $display("FAIL rms_new_row %0d: got %h required %h", i, cap_data[i], row_val(400 + i)); end
        end
        $display("test_reset_mid_send done: %0d rows in new frame", cap_data.size());
    endtask

    task automatic test_random_gaps();
        int n;
        clear_capture();
        write_rows(500, 32, 1'b1, 1'b0);
        repeat (50) @(negedge clk);
        #1;
        n = (cap_data.size() < 32) ? cap_data.size() : 32;
        checks++; if (cap_data.size() !== 32) begin errors++; $display("FAIL gaps_count: got %0d required 32", cap_data.size()); end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (cap_data[i] !== row_val(500 + i)) begin errors++; $display("FAIL gaps_row %0d: got %h required %h", i, cap_data[i], row_val(500 + i)); end
        end
        if (n == 32) begin
            for (int f = 0; f < 2; f++) begin
                checks++;
                if (cap_cyc[16*f + 15] - cap_cyc[16*f] !== 15) begin errors++; $display("FAIL gaps_frame %0d: span %0d required 15", f, cap_cyc[16*f + 15] - cap_cyc[16*f]); end
            end
        end
        checks++; if (zero_viol !== 0) begin errors++; $display("FAIL idle_zero: %0d nonzero idle cycles required 0", zero_viol); end
        $display("test_random_gaps done: %0d rows captured", cap_data.size());
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_flush_idle();
        test_flush_with_frame();
        test_reset_mid_send();
        test_random_gaps();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
